alu_instr_sequencer: RTL

- Multi-cycle control FSM that drives the existing ALU, flags and condition-check blocks.
- Each instruction is fetched from instruction memory at PC, decoded, issued to the ALU, gated by COND against the flags, and written back to the register file.
- Issues data-memory requests for LDR/STR over a REQ/ACK handshake.
- Sits between the instruction/data memories, the register bank and the ALU datapath.

---
 rtl/alu_instr_sequencer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer
//   Multi-cycle control FSM for the ALU datapath. It fetches from instruction
//   memory at PC, decodes, issues the operation to the external ALU, gates it by
//   COND against the architectural NZCV and writes back to the register bank.
//   LDR/STR go through a REQ/ACK data-memory handshake.
//
//   Build option: define DMEM_TIMEOUT_EN to bound the ACK wait in MEM to
//   TIMEOUT_CYCLES cycles (expiry sets ILLEGAL and halts). Without it, MEM waits
//   for ACK indefinitely.
//
// Ports
//   CLK, RESET                clock, synchronous active-high reset
//   IMEM_ADDR / IMEM_DATA     instruction address out, instruction in (1-cycle latency)
//   RF_RADDR1/2, RF_RDATA1/2  register read ports (combinational data)
//   RF_WE/WADDR/WDATA         register write port
//   ALU_OP/A/B                operation and operands to the ALU
//   ALU_RESULT/ALU_NZCV       combinational ALU result and flags
//   DMEM_REQ/WE/ADDR/WDATA    data-memory request (held until ACK)
//   DMEM_RDATA/DMEM_ACK       load data and one-cycle completion pulse
//   NZCV, PC                  architectural flags and program counter
//   HALTED, ILLEGAL           sticky status indicators
module alu_instr_sequencer #(
    parameter int PC_W           = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic [PC_W-1:0] IMEM_ADDR,
    input  logic [31:0]     IMEM_DATA,
    output logic [3:0]      RF_RADDR1,
    output logic [3:0]      RF_RADDR2,
    input  logic [31:0]     RF_RDATA1,
    input  logic [31:0]     RF_RDATA2,
    output logic            RF_WE,
    output logic [3:0]      RF_WADDR,
    output logic [31:0]     RF_WDATA,
    output logic [3:0]      ALU_OP,
    output logic [31:0]     ALU_A,
    output logic [31:0]     ALU_B,
    input  logic [31:0]     ALU_RESULT,
    input  logic [3:0]      ALU_NZCV,
    output logic            DMEM_REQ,
    output logic            DMEM_WE,
    output logic [PC_W-1:0] DMEM_ADDR,
    output logic [31:0]     DMEM_WDATA,
    input  logic [31:0]     DMEM_RDATA,
    input  logic            DMEM_ACK,
    output logic [3:0]      NZCV,
    output logic [PC_W-1:0] PC,
    output logic            HALTED,
    output logic            ILLEGAL
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LDR  = 4'hA;
    localparam logic [3:0] OP_STR  = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_ir;
    logic [PC_W-1:0]   r_pc;
    logic [3:0]        r_nzcv;
    logic              r_halted;
    logic              r_illegal;
    logic [31:0]       r_result;
    logic [3:0]        r_alu_flags;
    logic [PC_W-1:0]   r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic [3:0]        w_cond;
    logic [3:0]        w_opcode;
    logic              w_s;
    logic              w_i;
    logic [31:0]       w_operand_b;
    logic              w_dec_illegal;
    logic              w_cond_met;
    logic              w_is_mem_op;
    logic              w_flag_update;
    logic              w_tmo_expired;

    assign w_cond        = r_ir[31:28];
    assign w_opcode      = r_ir[27:24];
    assign w_s           = r_ir[23];
    assign w_i           = r_ir[22];
    assign w_operand_b   = w_i ? {22'd0, r_ir[9:0]} : RF_RDATA2;
    assign w_dec_illegal = (IMEM_DATA[27:24] == 4'hD) || (IMEM_DATA[27:24] == 4'hE);
    assign w_is_mem_op   = (w_opcode == OP_LDR) || (w_opcode == OP_STR);
    assign w_flag_update = (w_opcode == OP_CMP) || (w_s && (w_opcode <= 4'h8));

    // Condition check always uses the registered flags, so an instruction sees
    // the flags left by its predecessor's writeback.
    always_comb begin
        w_cond_met = 1'b0;
        case (w_cond)
            4'h0: w_cond_met = 1'b1;
            4'h1: w_cond_met = r_nzcv[2];
            4'h2: w_cond_met = !r_nzcv[2] && (r_nzcv[3] == r_nzcv[0]);
            4'h3: w_cond_met = (r_nzcv[3] != r_nzcv[0]);
            4'h4: w_cond_met = (r_nzcv[3] == r_nzcv[0]);
            4'h5: w_cond_met = r_nzcv[2] || (r_nzcv[3] != r_nzcv[0]);
            4'h6: w_cond_met = r_nzcv[1] && !r_nzcv[2];
            4'h7: w_cond_met = !r_nzcv[1];
            4'h8: w_cond_met = r_nzcv[1];
            default: w_cond_met = 1'b0;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts cycles spent with REQ high; cleared whenever not in MEM.
    always_ff @(posedge CLK) begin
        if (RESET || (r_state != S_MEM)) r_tmo_cnt <= '0;
        else                             r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end

    // Expires in the TIMEOUT_CYCLES-th REQ cycle; an ACK in that cycle wins.
    assign w_tmo_expired = (r_state == S_MEM) && !DMEM_ACK &&
                           (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_tmo_expired        = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:     w_next_state = S_DECODE;
            S_DECODE:    w_next_state = w_dec_illegal ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                if (!w_cond_met)               w_next_state = S_FETCH;
                else if (w_opcode == OP_HALT)  w_next_state = S_HALT;
                else if (w_is_mem_op)          w_next_state = S_MEM;
                else                           w_next_state = S_WRITEBACK;
            end
            S_MEM: begin
                if (DMEM_ACK)           w_next_state = (w_opcode == OP_LDR) ? S_WRITEBACK : S_FETCH;
                else if (w_tmo_expired) w_next_state = S_HALT;
            end
            S_WRITEBACK: w_next_state = S_FETCH;
            S_HALT:      w_next_state = S_HALT;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // Datapath / architectural registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ir        <= '0;
            r_pc        <= '0;
            r_nzcv      <= '0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            r_result    <= '0;
            r_alu_flags <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_DECODE: begin
                    r_ir <= IMEM_DATA;
                    if (w_dec_illegal) r_illegal <= 1'b1;
                end
                S_EXECUTE: begin
                    if (!w_cond_met) begin
                        r_pc <= r_pc + PC_W'(1);
                    end else if (w_opcode == OP_HALT) begin
                        r_halted <= 1'b1;
                    end else if (w_is_mem_op) begin
                        // Operands are captured so the request stays stable while waiting.
                        r_mem_addr  <= RF_RDATA1[PC_W-1:0];
                        r_mem_wdata <= w_operand_b;
                    end else begin
                        r_result    <= ALU_RESULT;
                        r_alu_flags <= ALU_NZCV;
                    end
                end
                S_MEM: begin
                    if (DMEM_ACK) begin
                        if (w_opcode == OP_LDR) r_result <= DMEM_RDATA;
                        else                    r_pc     <= r_pc + PC_W'(1);
                    end else if (w_tmo_expired) begin
                        r_illegal <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (w_flag_update) r_nzcv <= r_alu_flags;
                    r_pc <= r_pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        RF_WE    = 1'b0;
        DMEM_REQ = 1'b0;
        DMEM_WE  = 1'b0;
        case (r_state)
            S_MEM: begin
                DMEM_REQ = 1'b1;
                DMEM_WE  = (w_opcode == OP_STR);
            end
            S_WRITEBACK: RF_WE = (w_opcode != OP_CMP);
            default: ;
        endcase
    end

    assign IMEM_ADDR  = r_pc;
    assign RF_RADDR1  = r_ir[17:14];
    assign RF_RADDR2  = r_ir[13:10];
    assign RF_WADDR   = r_ir[21:18];
    assign RF_WDATA   = r_result;
    assign ALU_OP     = w_opcode;
    assign ALU_A      = RF_RDATA1;
    assign ALU_B      = w_operand_b;
    assign DMEM_ADDR  = r_mem_addr;
    assign DMEM_WDATA = r_mem_wdata;
    assign NZCV       = r_nzcv;
    assign PC         = r_pc;
    assign HALTED     = r_halted;
    assign ILLEGAL    = r_illegal;

endmodule
